// File: rtl/lisa_uart_rxfifo.sv
// Receive FIFO behind the LISA UART: drains its holding register through a
// three-state handshake and buffers bytes for the CPU, with a threshold/timeout IRQ.
module lisa_uart_rxfifo #(
  parameter int DEPTH_W = 3,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         uart_rx_d,
  input  logic               uart_rx_avail,
  output logic               uart_rx_rd,
  input  logic               cpu_rd,
  output logic [7:0]         cpu_d,
  output logic               cpu_avail,
  output logic [DEPTH_W:0]   count,
  input  logic [DEPTH_W:0]   thresh,
  output logic               overflow,
  input  logic               ovf_clr,
  input  logic               flush,
  output logic               irq
);

  localparam int                DEPTH    = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0]  FULL_CNT = (DEPTH_W+1)'(DEPTH);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_e;

  state_e             state, state_nxt;
  logic [7:0]         mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic [TO_W-1:0]    to_cnt;
  logic               to_flag;
  logic               push, pop, full, accept, ovf_set;

  // ---------------------------------------------------------------------------
  // Drain handshake
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      uart_rx_rd <= 1'b0;
    end else begin
      state      <= state_nxt;
      uart_rx_rd <= push;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    unique case (state)
      S_IDLE: if (uart_rx_avail) begin
                push      = 1'b1;
                state_nxt = S_ACK;
              end
      S_ACK:  state_nxt = S_HOLD;
      S_HOLD: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and occupancy
  // ---------------------------------------------------------------------------
  assign cpu_avail = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = cpu_rd && cpu_avail;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign accept    = push && !flush && (!full || pop);
  assign ovf_set   = push && !flush && full && !pop;
  assign cpu_d     = cpu_avail ? mem[rd_ptr] : 8'h00;

  // NOTE: the storage array has no reset; entries are only observable once
  // count says they were written, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= uart_rx_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
    end
  end

  // Set wins over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Idle timeout and interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (flush || push || pop || !cpu_avail) begin
      to_cnt <= '0;
      if (flush || push || pop) to_flag <= 1'b0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TO_LAST) to_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= ((thresh != '0) && (count >= thresh)) || to_flag;
  end

endmodule

// File: tb/tb_lisa_uart_rxfifo.sv
// Bench for lisa_uart_rxfifo: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model and a read-data scoreboard.
module tb_lisa_uart_rxfifo;

  localparam int DEPTH_W = 3;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 10;
  localparam int DEPTH   = 1 << DEPTH_W;

  logic               clk;
  logic               rst_n;
  logic [7:0]         uart_rx_d;
  logic               uart_rx_avail;
  logic               uart_rx_rd;
  logic               cpu_rd;
  logic [7:0]         cpu_d;
  logic               cpu_avail;
  logic [DEPTH_W:0]   count;
  logic [DEPTH_W:0]   thresh;
  logic               overflow;
  logic               ovf_clr;
  logic               flush;
  logic               irq;

  lisa_uart_rxfifo #(
    .DEPTH_W(DEPTH_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .uart_rx_d(uart_rx_d), .uart_rx_avail(uart_rx_avail), .uart_rx_rd(uart_rx_rd),
    .cpu_rd(cpu_rd), .cpu_d(cpu_d), .cpu_avail(cpu_avail), .count(count),
    .thresh(thresh), .overflow(overflow), .ovf_clr(ovf_clr), .flush(flush), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, plus the handshake cooldown,
  // the idle-cycle count, and the flags the outputs are derived from.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int m_cool = 0;
  int m_idle = 0;
  bit m_to   = 1'b0;
  bit m_ovf  = 1'b0;
  bit m_irq  = 1'b0;

  task automatic model_step();
    int sz;
    bit push, pop;
    if (!rst_n) begin
      m_q.delete();
      m_cool = 0; m_idle = 0; m_to = 1'b0; m_ovf = 1'b0; m_irq = 1'b0;
      return;
    end
    sz   = m_q.size();
    push = (m_cool == 0) && uart_rx_avail;
    pop  = cpu_rd && (sz > 0);
    m_irq  = ((thresh != 0) && (sz >= int'(thresh))) || m_to;
    m_cool = push ? 2 : ((m_cool > 0) ? m_cool - 1 : 0);
    if (push && !flush && (sz == DEPTH) && !pop) m_ovf = 1'b1;
    else if (ovf_clr)                             m_ovf = 1'b0;
    if (flush) begin
      m_q.delete();
      m_idle = 0;
      m_to   = 1'b0;
    end else begin
      if (push || pop || sz == 0) begin
        m_idle = 0;
        if (push || pop) m_to = 1'b0;
      end else if (m_idle < TIMEOUT) begin
        m_idle++;
        if (m_idle == TIMEOUT) m_to = 1'b1;
      end
      if (pop) void'(m_q.pop_front());
      if (push && (sz < DEPTH || pop)) m_q.push_back(uart_rx_d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Issuing a read records the byte the CPU should see on cpu_d.
  task automatic set_rd(input bit v);
    cpu_rd = v;
    if (v && m_q.size() > 0) exp_q.push_back(m_q[0]);
  endtask

  // UART-like source: holds avail high through ACK and HOLD.
  task automatic send_byte(input logic [7:0] b, input bit rd, input bit clr);
    uart_rx_d = b; uart_rx_avail = 1'b1; set_rd(rd); ovf_clr = clr;
    tick();
    set_rd(1'b0); ovf_clr = 1'b0;
    tick();
    tick();
    uart_rx_avail = 1'b0;
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      set_rd(1'b1);
      tick();
    end
    set_rd(1'b0);
  endtask

  // Monitor: per-cycle status against the model, read data against the scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(m_q.size()));
      check("cpu_avail", 32'(cpu_avail), 32'(m_q.size() != 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("irq", 32'(irq), 32'(m_irq));
      check("uart_rx_rd", 32'(uart_rx_rd), 32'(m_cool == 2));
      if (m_q.size() == 0) check("cpu_d_empty", 32'(cpu_d), 32'h0);
      if (cpu_rd && (cpu_avail || exp_q.size() != 0)) begin
        if (exp_q.size() == 0) check("rd_unexpected", 32'(cpu_avail), 32'h0);
        else                   check("rd_data", 32'(cpu_d), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; uart_rx_d = 8'h00; uart_rx_avail = 1'b0; cpu_rd = 1'b0;
    thresh = '0; ovf_clr = 1'b0; flush = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_count", 32'(count), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    tick();

    // First byte: one-edge latency, single rd pulse, no re-push in HOLD.
    uart_rx_d = 8'hA5; uart_rx_avail = 1'b1;
    tick();
    check("a5_count", 32'(count), 32'h1);
    check("a5_data", 32'(cpu_d), 32'hA5);
    check("a5_rd_ack", 32'(uart_rx_rd), 32'h1);
    tick();
    check("a5_rd_hold", 32'(uart_rx_rd), 32'h0);
    tick();
    check("a5_no_repush", 32'(count), 32'h1);
    uart_rx_avail = 1'b0;
    read_n(1);

    // Fill, overflow on the 9th byte, drain in order.
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0, 1'b0);
    check("ovf_count", 32'(count), 32'h8);
    check("ovf_flag", 32'(overflow), 32'h1);
    read_n(8);
    check("drain_avail", 32'(cpu_avail), 32'h0);
    check("drain_cpu_d", 32'(cpu_d), 32'h0);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

    // Full FIFO with a pop in the push cycle: push accepted, no overflow.
    for (int i = 1; i <= 8; i++) send_byte(8'(8'h20 + i), 1'b0, 1'b0);
    send_byte(8'h10, 1'b1, 1'b0);
    check("full_pp_count", 32'(count), 32'h8);
    check("full_pp_ovf", 32'(overflow), 32'h0);
    read_n(7);
    check("full_pp_last", 32'(cpu_d), 32'h10);
    read_n(1);

    // Pointer wrap: 20 push/pop pairs.
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(i * 7 + 3), 1'b0, 1'b0);
      read_n(1);
    end
    check("wrap_count", 32'(count), 32'h0);

    // Threshold interrupt.
    thresh = 4'd3;
    send_byte(8'h31, 1'b0, 1'b0);
    send_byte(8'h32, 1'b0, 1'b0);
    uart_rx_d = 8'h33; uart_rx_avail = 1'b1;
    tick();
    check("thr_count3", 32'(count), 32'h3);
    check("thr_irq_lag", 32'(irq), 32'h0);
    tick();
    check("thr_irq_set", 32'(irq), 32'h1);
    tick();
    uart_rx_avail = 1'b0;
    read_n(1);
    check("thr_irq_hold", 32'(irq), 32'h1);
    tick();
    check("thr_irq_clr", 32'(irq), 32'h0);
    read_n(2);
    thresh = '0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h40 + i), 1'b0, 1'b0);
    check("thr0_irq", 32'(irq), 32'h0);
    read_n(8);

    // Idle timeout: irq 11 edges after the push.
    uart_rx_d = 8'h77; uart_rx_avail = 1'b1;
    tick();
    uart_rx_avail = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (irq) lat = k;
    end
    check("to_latency", 32'(lat), 32'd11);
    read_n(1);
    check("to_irq_lag", 32'(irq), 32'h1);
    tick();
    check("to_irq_clr", 32'(irq), 32'h0);

    // Flush with a coincident push.
    send_byte(8'h51, 1'b0, 1'b0);
    send_byte(8'h52, 1'b0, 1'b0);
    uart_rx_d = 8'hEE; uart_rx_avail = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", 32'(count), 32'h0);
    check("flush_no_ovf", 32'(overflow), 32'h0);
    tick(); tick();
    uart_rx_avail = 1'b0;

    // ovf_clr coinciding with an overflow keeps it set.
    for (int i = 0; i < 8; i++) send_byte(8'(8'h60 + i), 1'b0, 1'b0);
    send_byte(8'h99, 1'b0, 1'b1);
    check("ovfclr_flag", 32'(overflow), 32'h1);
    check("ovfclr_count", 32'(count), 32'h8);
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush2_count", 32'(count), 32'h0);
    check("flush2_ovf", 32'(overflow), 32'h1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

    // Reset during ACK, then the still-pending byte is drained again.
    uart_rx_d = 8'h5A; uart_rx_avail = 1'b1;
    tick();
    check("rstack_rd", 32'(uart_rx_rd), 32'h1);
    rst_n = 1'b0;
    tick();
    check("rstack_rd_clr", 32'(uart_rx_rd), 32'h0);
    check("rstack_count", 32'(count), 32'h0);
    rst_n = 1'b1;
    tick();
    check("redrain_count", 32'(count), 32'h1);
    check("redrain_data", 32'(cpu_d), 32'h5A);
    uart_rx_avail = 1'b0;
    tick(); tick();
    read_n(1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      uart_rx_avail = ($urandom_range(0, 99) < 50);
      uart_rx_d     = 8'($urandom);
      set_rd($urandom_range(0, 99) < 35);
      flush   = ($urandom_range(0, 99) < 2);
      ovf_clr = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) == 0) thresh = 4'($urandom_range(0, 8));
      tick();
    end
    uart_rx_avail = 1'b0; flush = 1'b0; ovf_clr = 1'b0; set_rd(1'b0);
    tick(); tick(); tick();
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
